// File: rtl/sdrc_req_arbiter.sv
// Two-port request arbiter in front of an SDRAM controller application interface.
// A round-robin grant is taken in IDLE; the owner then keeps the controller through one request and its data beats.
module sdrc_req_arbiter #(
    parameter int APP_AW = 26,
    parameter int APP_DW = 32,
    parameter int APP_RW = 9
) (
    input  logic                  sdram_clk,
    input  logic                  sdram_resetn,

    input  logic                  p0_req,
    input  logic [APP_AW-1:0]     p0_req_addr,
    input  logic [APP_RW-1:0]     p0_req_len,
    input  logic                  p0_req_wr_n,
    input  logic [APP_DW-1:0]     p0_wr_data,
    input  logic [APP_DW/8-1:0]   p0_wr_en_n,
    output logic                  p0_req_ack,
    output logic                  p0_wr_next,
    output logic                  p0_rd_valid,
    output logic [APP_DW-1:0]     p0_rd_data,
    output logic                  p0_last,

    input  logic                  p1_req,
    input  logic [APP_AW-1:0]     p1_req_addr,
    input  logic [APP_RW-1:0]     p1_req_len,
    input  logic                  p1_req_wr_n,
    input  logic [APP_DW-1:0]     p1_wr_data,
    input  logic [APP_DW/8-1:0]   p1_wr_en_n,
    output logic                  p1_req_ack,
    output logic                  p1_wr_next,
    output logic                  p1_rd_valid,
    output logic [APP_DW-1:0]     p1_rd_data,
    output logic                  p1_last,

    output logic                  app_req,
    output logic [APP_AW-1:0]     app_req_addr,
    output logic [APP_RW-1:0]     app_req_len,
    output logic                  app_req_wr_n,
    output logic [APP_DW-1:0]     app_wr_data,
    output logic [APP_DW/8-1:0]   app_wr_en_n,
    input  logic                  app_req_ack,
    input  logic                  app_wr_next,
    input  logic                  app_rd_valid,
    input  logic [APP_DW-1:0]     app_rd_data,
    input  logic                  app_last_wr,
    input  logic                  app_last_rd,

    output logic                  busy,
    output logic                  grant,
    output logic                  err_len
);

    localparam int BW = APP_DW / 8;
    localparam logic [APP_RW-1:0] BEAT_ONE = {{(APP_RW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                grant_q, grant_d;
    logic                last_grant_q, last_grant_d;
    logic [APP_RW-1:0]   beat_q, beat_d;
    logic [APP_RW-1:0]   len_q, len_d;
    logic                wr_n_q, wr_n_d;

    logic                win;
    logic                len_zero;
    logic                beat_strb;
    logic                xfer_end;
    logic [APP_RW-1:0]   beat_inc;

    logic [APP_AW-1:0]   sel_addr;
    logic [APP_RW-1:0]   sel_len;
    logic                sel_wr_n;
    logic [APP_DW-1:0]   sel_wr_data;
    logic [BW-1:0]       sel_wr_en_n;

    logic                req_ack_int;
    logic                wr_next_int;
    logic                rd_valid_int;
    logic                last_int;

    // Request fields always follow the registered owner, so the write path is stable before XFER.
    assign sel_addr    = grant_q ? p1_req_addr : p0_req_addr;
    assign sel_len     = grant_q ? p1_req_len  : p0_req_len;
    assign sel_wr_n    = grant_q ? p1_req_wr_n : p0_req_wr_n;
    assign sel_wr_data = grant_q ? p1_wr_data  : p0_wr_data;
    assign sel_wr_en_n = grant_q ? p1_wr_en_n  : p0_wr_en_n;

    // Both requesting: the port that did not own the last transfer goes first.
    assign win       = (p0_req && p1_req) ? ~last_grant_q : p1_req;
    assign len_zero  = (len_q == '0);
    assign beat_inc  = beat_q + BEAT_ONE;
    assign beat_strb = (state_q == ST_XFER) && (wr_n_q ? app_rd_valid : app_wr_next);
    assign xfer_end  = beat_strb && (wr_n_q ? app_last_rd : app_last_wr);

    always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
        if (!sdram_resetn) begin
            state_q      <= ST_IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            beat_q       <= '0;
            len_q        <= '0;
            wr_n_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            beat_q       <= beat_d;
            len_q        <= len_d;
            wr_n_q       <= wr_n_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        beat_d       = beat_q;
        len_d        = len_q;
        wr_n_d       = wr_n_q;
        case (state_q)
            ST_IDLE: begin
                if (p0_req || p1_req) begin
                    grant_d = win;
                    len_d   = win ? p1_req_len  : p0_req_len;
                    wr_n_d  = win ? p1_req_wr_n : p0_req_wr_n;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // A zero-length request is swallowed here and still counts as a turn.
                if (len_zero) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end else if (app_req_ack) begin
                    beat_d  = '0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (beat_strb) begin
                    beat_d = beat_inc;
                end
                if (xfer_end) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_comb begin
        app_req      = 1'b0;
        app_req_addr = '0;
        app_req_len  = '0;
        app_req_wr_n = 1'b1;
        req_ack_int  = 1'b0;
        wr_next_int  = 1'b0;
        rd_valid_int = 1'b0;
        last_int     = 1'b0;
        err_len      = 1'b0;
        case (state_q)
            ST_REQ: begin
                app_req      = ~len_zero;
                app_req_addr = sel_addr;
                app_req_len  = sel_len;
                app_req_wr_n = sel_wr_n;
                req_ack_int  = len_zero | app_req_ack;
                err_len      = len_zero;
            end
            ST_XFER: begin
                wr_next_int  = ~wr_n_q & app_wr_next;
                rd_valid_int = wr_n_q & app_rd_valid;
                last_int     = xfer_end;
                err_len      = xfer_end && (beat_inc != len_q);
            end
            default: begin
            end
        endcase

        p0_req_ack  = req_ack_int  & ~grant_q;
        p1_req_ack  = req_ack_int  &  grant_q;
        p0_wr_next  = wr_next_int  & ~grant_q;
        p1_wr_next  = wr_next_int  &  grant_q;
        p0_rd_valid = rd_valid_int & ~grant_q;
        p1_rd_valid = rd_valid_int &  grant_q;
        p0_last     = last_int     & ~grant_q;
        p1_last     = last_int     &  grant_q;
    end

    // Pass-through data paths are forced to their idle values while reset is held.
    assign app_wr_data = sdram_resetn ? sel_wr_data : '0;
    assign app_wr_en_n = sdram_resetn ? sel_wr_en_n : '1;
    assign p0_rd_data  = sdram_resetn ? app_rd_data : '0;
    assign p1_rd_data  = sdram_resetn ? app_rd_data : '0;

    assign busy  = (state_q != ST_IDLE);
    assign grant = grant_q;

endmodule

// File: tb/tb_sdrc_req_arbiter.sv
// Bench for sdrc_req_arbiter: scripted cycle table, reset abort sequence, and a randomized
// transaction loop checked against a round-robin transfer model.
module tb_sdrc_req_arbiter;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int RW = 9;
    localparam int BW = DW / 8;

    logic            sdram_clk = 1'b0;
    logic            sdram_resetn;
    logic            p0_req, p1_req;
    logic [AW-1:0]   p0_req_addr, p1_req_addr;
    logic [RW-1:0]   p0_req_len, p1_req_len;
    logic            p0_req_wr_n, p1_req_wr_n;
    logic [DW-1:0]   p0_wr_data, p1_wr_data;
    logic [BW-1:0]   p0_wr_en_n, p1_wr_en_n;
    logic            p0_req_ack, p1_req_ack;
    logic            p0_wr_next, p1_wr_next;
    logic            p0_rd_valid, p1_rd_valid;
    logic [DW-1:0]   p0_rd_data, p1_rd_data;
    logic            p0_last, p1_last;
    logic            app_req;
    logic [AW-1:0]   app_req_addr;
    logic [RW-1:0]   app_req_len;
    logic            app_req_wr_n;
    logic [DW-1:0]   app_wr_data;
    logic [BW-1:0]   app_wr_en_n;
    logic            app_req_ack, app_wr_next, app_rd_valid;
    logic [DW-1:0]   app_rd_data;
    logic            app_last_wr, app_last_rd;
    logic            busy, grant, err_len;

    sdrc_req_arbiter #(.APP_AW(AW), .APP_DW(DW), .APP_RW(RW)) dut (
        .sdram_clk(sdram_clk), .sdram_resetn(sdram_resetn),
        .p0_req(p0_req), .p0_req_addr(p0_req_addr), .p0_req_len(p0_req_len),
        .p0_req_wr_n(p0_req_wr_n), .p0_wr_data(p0_wr_data), .p0_wr_en_n(p0_wr_en_n),
        .p0_req_ack(p0_req_ack), .p0_wr_next(p0_wr_next), .p0_rd_valid(p0_rd_valid),
        .p0_rd_data(p0_rd_data), .p0_last(p0_last),
        .p1_req(p1_req), .p1_req_addr(p1_req_addr), .p1_req_len(p1_req_len),
        .p1_req_wr_n(p1_req_wr_n), .p1_wr_data(p1_wr_data), .p1_wr_en_n(p1_wr_en_n),
        .p1_req_ack(p1_req_ack), .p1_wr_next(p1_wr_next), .p1_rd_valid(p1_rd_valid),
        .p1_rd_data(p1_rd_data), .p1_last(p1_last),
        .app_req(app_req), .app_req_addr(app_req_addr), .app_req_len(app_req_len),
        .app_req_wr_n(app_req_wr_n), .app_wr_data(app_wr_data), .app_wr_en_n(app_wr_en_n),
        .app_req_ack(app_req_ack), .app_wr_next(app_wr_next), .app_rd_valid(app_rd_valid),
        .app_rd_data(app_rd_data), .app_last_wr(app_last_wr), .app_last_rd(app_last_rd),
        .busy(busy), .grant(grant), .err_len(err_len)
    );

    // ---------------- clock / reset ----------------
    initial forever #5 sdram_clk = ~sdram_clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard counters ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge sdram_clk);
        #1;
    endtask

    task automatic clear_ctl();
        app_req_ack  = 1'b0;
        app_wr_next  = 1'b0;
        app_rd_valid = 1'b0;
        app_last_wr  = 1'b0;
        app_last_rd  = 1'b0;
    endtask

    // ---------------- table vectors ----------------
    // ctl  = {app_req_ack, app_wr_next, app_rd_valid, app_last_wr, app_last_rd}
    // exp  = {app_req, ack0, ack1, wr_next0, wr_next1, rd_valid0, rd_valid1, last0, last1, err_len, busy, grant}
    typedef struct {
        logic [1:0]    req;
        logic [RW-1:0] len0;
        logic [RW-1:0] len1;
        logic [1:0]    wrn;
        logic [4:0]    ctl;
        logic [11:0]   exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic [1:0] req, input int len0, input int len1,
                                input logic [1:0] wrn, input logic [4:0] ctl, input logic [11:0] exp);
        vec_t v;
        v.req  = req;
        v.len0 = RW'(len0);
        v.len1 = RW'(len1);
        v.wrn  = wrn;
        v.ctl  = ctl;
        v.exp  = exp;
        vecs.push_back(v);
    endfunction

    localparam logic [AW-1:0] A0 = 26'h0_1234;
    localparam logic [AW-1:0] A1 = 26'h2_ABCD;
    localparam logic [DW-1:0] D0 = 32'hA0A0_5151;
    localparam logic [DW-1:0] D1 = 32'h1B1B_E7E7;
    localparam logic [BW-1:0] E0 = 4'h5;
    localparam logic [BW-1:0] E1 = 4'hA;

    // ---------------- reference model state ----------------
    int            last_g;
    bit            pend[2];
    logic [RW-1:0] m_len[2];
    logic          m_wrn[2];
    logic [AW-1:0] m_addr[2];
    logic [DW-1:0] m_data[2];
    logic [BW-1:0] m_be[2];

    task automatic new_req(input int p);
        pend[p]   = 1'b1;
        m_len[p]  = RW'($urandom_range(0, 4));
        m_wrn[p]  = 1'($urandom_range(0, 1));
        m_addr[p] = AW'($urandom);
        m_data[p] = $urandom;
        m_be[p]   = BW'($urandom);
    endtask

    task automatic apply_ports();
        p0_req = pend[0]; p0_req_len = m_len[0]; p0_req_wr_n = m_wrn[0];
        p0_req_addr = m_addr[0]; p0_wr_data = m_data[0]; p0_wr_en_n = m_be[0];
        p1_req = pend[1]; p1_req_len = m_len[1]; p1_req_wr_n = m_wrn[1];
        p1_req_addr = m_addr[1]; p1_wr_data = m_data[1]; p1_wr_en_n = m_be[1];
    endtask

    // {req_ack, wr_next, rd_valid, last} seen by port p
    function automatic logic [3:0] pouts(input int p);
        if (p == 1) return {p1_req_ack, p1_wr_next, p1_rd_valid, p1_last};
        return {p0_req_ack, p0_wr_next, p0_rd_valid, p0_last};
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        logic [11:0]   act;
        logic [DW-1:0] rdv;
        int w, o, k, gaps;

        // reset with live-looking inputs: outputs must still show reset values
        sdram_resetn = 1'b0;
        p0_req = 1'b1; p1_req = 1'b1;
        p0_req_addr = A0; p1_req_addr = A1;
        p0_req_len = 9'd3; p1_req_len = 9'd3;
        p0_req_wr_n = 1'b0; p1_req_wr_n = 1'b0;
        p0_wr_data = D0; p1_wr_data = D1;
        p0_wr_en_n = E0; p1_wr_en_n = E1;
        clear_ctl();
        app_rd_data = 32'hCAFE_F00D;
        app_wr_next = 1'b1;
        #12;
        chk("rst_busy",    64'(busy), 64'd0);
        chk("rst_grant",   64'(grant), 64'd0);
        chk("rst_app_req", 64'({app_req, app_req_addr, app_req_len}), 64'd0);
        chk("rst_wr_n",    64'(app_req_wr_n), 64'd1);
        chk("rst_wr_data", 64'(app_wr_data), 64'd0);
        chk("rst_wr_en_n", 64'(app_wr_en_n), 64'hF);
        chk("rst_rd_data", 64'({p0_rd_data, p1_rd_data}), 64'd0);
        chk("rst_ports",   64'({pouts(0), pouts(1), err_len}), 64'd0);
        p0_req = 1'b0; p1_req = 1'b0;
        clear_ctl();
        @(posedge sdram_clk);
        #1 sdram_resetn = 1'b1;
        tick();

        // both request from reset: p0, then p1, then p0 again
        add(2'b11, 1, 1, 2'b11, 5'b00000, 12'b000000000000);
        add(2'b11, 1, 1, 2'b11, 5'b10000, 12'b110000000010);
        add(2'b01, 1, 1, 2'b11, 5'b00101, 12'b000001010010);
        add(2'b11, 1, 1, 2'b11, 5'b00000, 12'b000000000000);
        add(2'b11, 1, 1, 2'b11, 5'b10000, 12'b101000000011);
        add(2'b10, 1, 1, 2'b11, 5'b00101, 12'b000000101011);
        add(2'b10, 1, 1, 2'b11, 5'b00000, 12'b000000000001);
        add(2'b10, 1, 1, 2'b11, 5'b10000, 12'b110000000010);
        add(2'b00, 1, 1, 2'b11, 5'b00101, 12'b000001010010);
        // p0 write len 4, controller acks on the third REQ cycle
        add(2'b10, 4, 1, 2'b01, 5'b00000, 12'b000000000000);
        add(2'b10, 4, 1, 2'b01, 5'b00000, 12'b100000000010);
        add(2'b10, 4, 1, 2'b01, 5'b00000, 12'b100000000010);
        add(2'b10, 4, 1, 2'b01, 5'b10000, 12'b110000000010);
        add(2'b00, 4, 1, 2'b01, 5'b01000, 12'b000100000010);
        add(2'b00, 4, 1, 2'b01, 5'b00000, 12'b000000000010);
        add(2'b00, 4, 1, 2'b01, 5'b01000, 12'b000100000010);
        add(2'b00, 4, 1, 2'b01, 5'b01101, 12'b000100000010);
        add(2'b00, 4, 1, 2'b01, 5'b01010, 12'b000100010010);
        add(2'b00, 4, 1, 2'b01, 5'b00000, 12'b000000000000);
        // p1 read len 2 while p0 waits; then p0 read len 4 ending early on beat 3
        add(2'b01, 4, 2, 2'b11, 5'b00000, 12'b000000000000);
        add(2'b11, 4, 2, 2'b11, 5'b10000, 12'b101000000011);
        add(2'b10, 4, 2, 2'b11, 5'b00100, 12'b000000100011);
        add(2'b10, 4, 2, 2'b11, 5'b00000, 12'b000000000011);
        add(2'b10, 4, 2, 2'b11, 5'b00101, 12'b000000101011);
        add(2'b10, 4, 2, 2'b11, 5'b00000, 12'b000000000001);
        add(2'b10, 4, 2, 2'b11, 5'b10000, 12'b110000000010);
        add(2'b00, 4, 2, 2'b11, 5'b01100, 12'b000001000010);
        add(2'b00, 4, 2, 2'b11, 5'b00110, 12'b000001000010);
        add(2'b00, 4, 2, 2'b11, 5'b00101, 12'b000001010110);
        add(2'b00, 4, 2, 2'b11, 5'b00000, 12'b000000000000);
        // p1 zero-length request
        add(2'b01, 4, 0, 2'b11, 5'b00000, 12'b000000000000);
        add(2'b01, 4, 0, 2'b11, 5'b00000, 12'b001000000111);
        add(2'b00, 4, 0, 2'b11, 5'b00000, 12'b000000000001);

        for (int i = 0; i < vecs.size(); i++) begin
            {p0_req, p1_req} = vecs[i].req;
            p0_req_len = vecs[i].len0;
            p1_req_len = vecs[i].len1;
            {p0_req_wr_n, p1_req_wr_n} = vecs[i].wrn;
            {app_req_ack, app_wr_next, app_rd_valid, app_last_wr, app_last_rd} = vecs[i].ctl;
            rdv = $urandom;
            app_rd_data = rdv;
            #1;
            act = {app_req, p0_req_ack, p1_req_ack, p0_wr_next, p1_wr_next, p0_rd_valid,
                   p1_rd_valid, p0_last, p1_last, err_len, busy, grant};
            chk($sformatf("vec%0d_ctl", i), 64'(act), 64'(vecs[i].exp));
            chk($sformatf("vec%0d_wdata", i), 64'({app_wr_data, app_wr_en_n}),
                vecs[i].exp[0] ? 64'({D1, E1}) : 64'({D0, E0}));
            chk($sformatf("vec%0d_rdata", i), 64'({p0_rd_data, p1_rd_data}), {rdv, rdv});
            if (vecs[i].exp[11])
                chk($sformatf("vec%0d_addr", i), 64'({app_req_addr, app_req_len}),
                    vecs[i].exp[0] ? 64'({A1, vecs[i].len1}) : 64'({A0, vecs[i].len0}));
            tick();
        end
        clear_ctl();

        // reset during a p1 write transfer
        p1_req = 1'b1; p1_req_len = 9'd8; p1_req_wr_n = 1'b0;
        #1 tick();
        app_req_ack = 1'b1;
        #1 chk("abort_ack", 64'(pouts(1)), 64'b1000);
        tick();
        p1_req = 1'b0; app_req_ack = 1'b0; app_wr_next = 1'b1;
        #1 chk("abort_beat", 64'({pouts(1), busy, grant}), 64'b010011);
        tick();
        sdram_resetn = 1'b0;
        app_last_wr = 1'b1; app_rd_valid = 1'b1; app_last_rd = 1'b1;
        app_rd_data = 32'hDEAD_BEEF;
        #1;
        chk("abort_busy_grant", 64'({busy, grant, app_req}), 64'd0);
        chk("abort_ports", 64'({pouts(0), pouts(1), err_len}), 64'd0);
        chk("abort_app", 64'({app_req_wr_n, app_wr_en_n, app_wr_data}), {27'd0, 1'b1, 4'hF, 32'd0});
        chk("abort_rd_data", 64'({p0_rd_data, p1_rd_data}), 64'd0);
        tick();
        clear_ctl();
        sdram_resetn = 1'b1;
        #1 chk("abort_after", 64'({busy, grant, pouts(1), err_len}), 64'd0);

        // randomized transactions against the transfer model
        last_g = 1;
        pend[0] = 1'b0; pend[1] = 1'b0;
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 1) == 1) new_req(p);
            if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
            apply_ports();
            clear_ctl();
            #1 chk($sformatf("r%0d_idle", t), 64'({busy, err_len, app_req}), 64'd0);
            tick();
            w = (pend[0] && pend[1]) ? 1 - last_g : (pend[1] ? 1 : 0);
            o = 1 - w;
            chk($sformatf("r%0d_grant", t), 64'({busy, grant}), 64'({1'b1, w[0]}));
            if (m_len[w] == 0) begin
                chk($sformatf("r%0d_zero", t), 64'({app_req, err_len, pouts(w), pouts(o)}),
                    64'({1'b0, 1'b1, 4'b1000, 4'b0000}));
                tick();
            end else begin
                gaps = $urandom_range(0, 2);
                for (int g = 0; g < gaps; g++) begin
                    chk($sformatf("r%0d_req", t), 64'({app_req, app_req_wr_n, app_req_len, app_req_addr}),
                        64'({1'b1, m_wrn[w], m_len[w], m_addr[w]}));
                    chk($sformatf("r%0d_noack", t), 64'({pouts(0), pouts(1)}), 64'd0);
                    tick();
                end
                app_req_ack = 1'b1;
                #1 chk($sformatf("r%0d_ack", t), 64'({app_req, pouts(w), pouts(o)}),
                       64'({1'b1, 4'b1000, 4'b0000}));
                tick();
                app_req_ack = 1'b0;
                pend[w] = 1'b0;
                apply_ports();
                k = m_len[w];
                case ($urandom_range(0, 3))
                    0: if (k > 1) k = k - 1;
                    1: k = k + 1;
                    default: ;
                endcase
                for (int b = 1; b <= k; b++) begin
                    if ($urandom_range(0, 2) == 0) begin
                        clear_ctl();
                        app_wr_next  = m_wrn[w] & 1'($urandom_range(0, 1));
                        app_rd_valid = ~m_wrn[w] & 1'($urandom_range(0, 1));
                        app_last_wr  = 1'($urandom_range(0, 1));
                        app_last_rd  = 1'($urandom_range(0, 1));
                        #1 chk($sformatf("r%0d_gap", t), 64'({busy, err_len, pouts(0), pouts(1)}),
                               64'({1'b1, 9'd0}));
                        tick();
                    end
                    clear_ctl();
                    rdv = $urandom;
                    app_rd_data  = rdv;
                    app_wr_next  = m_wrn[w] ? 1'($urandom_range(0, 1)) : 1'b1;
                    app_rd_valid = m_wrn[w] ? 1'b1 : 1'($urandom_range(0, 1));
                    app_last_wr  = m_wrn[w] ? 1'($urandom_range(0, 1)) : (b == k);
                    app_last_rd  = m_wrn[w] ? (b == k) : 1'($urandom_range(0, 1));
                    #1;
                    chk($sformatf("r%0d_b%0d_own", t, b), 64'(pouts(w)),
                        64'({1'b0, ~m_wrn[w], m_wrn[w], (b == k)}));
                    chk($sformatf("r%0d_b%0d_other", t, b), 64'(pouts(o)), 64'd0);
                    chk($sformatf("r%0d_b%0d_err", t, b), 64'(err_len),
                        64'((b == k) && (k != int'(m_len[w]))));
                    chk($sformatf("r%0d_b%0d_data", t, b),
                        64'({app_wr_data, app_wr_en_n, p0_rd_data == rdv, p1_rd_data == rdv}),
                        64'({m_data[w], m_be[w], 2'b11}));
                    tick();
                end
                clear_ctl();
            end
            pend[w] = 1'b0;
            last_g  = w;
            apply_ports();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sdrc_req_arbiter.md
SDRC_REQ_ARBITER -- requirements
Module: sdrc_req_arbiter

Interface
REQ-001 Parameter APP_AW, default 26, application request address width.
REQ-002 Parameter APP_DW, default 32, application data width.
REQ-003 Parameter APP_RW, default 9, request length width in words.
REQ-004 Ports, one per line, as name, direction, width, meaning:
- sdram_clk  in  1  single clock; all logic on the rising edge.
- sdram_resetn  in  1  asynchronous, active-low reset.
- pN_req  in  1  request from port N (N = 0, 1); held until pN_req_ack.
- pN_req_addr  in  APP_AW  request address.
- pN_req_len  in  APP_RW  request length in words.
- pN_req_wr_n  in  1  0 = write, 1 = read.
- pN_wr_data  in  APP_DW  write data.
- pN_wr_en_n  in  APP_DW/8  byte enables, active low.
- pN_req_ack  out  1  request accepted.
- pN_wr_next  out  1  consume the current write word.
- pN_rd_valid  out  1  read word valid.
- pN_rd_data  out  APP_DW  read data.
- pN_last  out  1  last word of the transfer.
- app_req  out  1  request to the SDRAM controller.
- app_req_addr  out  APP_AW  muxed address.
- app_req_len  out  APP_RW  muxed length.
- app_req_wr_n  out  1  muxed direction.
- app_wr_data  out  APP_DW  muxed write data.
- app_wr_en_n  out  APP_DW/8  muxed byte enables.
- app_req_ack  in  1  controller accepted the request.
- app_wr_next  in  1  controller consumed a write word.
- app_rd_valid  in  1  controller read word valid.
- app_rd_data  in  APP_DW  controller read data.
- app_last_wr  in  1  last write word.
- app_last_rd  in  1  last read word.
- busy  out  1  state is not IDLE.
- grant  out  1  index of the owning port.
- err_len  out  1  one-cycle pulse on a length error.

Function
REQ-005 The block shall implement a state machine with states IDLE, REQ and XFER.
REQ-006 In IDLE, when any pN_req is high, the block shall register grant and enter REQ on the next edge.
- Both ports requesting: the port other than last_grant wins (round-robin).
- One port requesting: that port wins.
REQ-007 In REQ, app_req shall equal 1 and app_req_addr, len, wr_n shall be driven from the granted port; in all other states app_req shall equal 0.
REQ-008 In REQ, app_req_ack shall be passed combinationally to pN_req_ack of the granted port only; the state then moves to XFER and the beat counter clears.
REQ-009 In XFER, for a write grant:
- app_wr_next is routed to pN_wr_next of the owner.
- app_wr_data and app_wr_en_n follow the owner's pN_wr_data and pN_wr_en_n.
REQ-010 In XFER, for a read grant:
- app_rd_valid and app_rd_data are routed to pN_rd_valid and pN_rd_data of the owner.
REQ-011 The non-owning port shall see pN_wr_next = 0, pN_rd_valid = 0, pN_last = 0 and pN_req_ack = 0 at all times.
REQ-012 The beat counter (APP_RW bits) shall increment on each routed app_wr_next or app_rd_valid.
REQ-013 The transfer shall end when app_last_wr (write) or app_last_rd (read) is high together with its beat:
- pN_last is asserted that cycle.
- last_grant <= grant.
- The state returns to IDLE.
REQ-014 If the transfer ends with beat count + 1 not equal to the latched length, err_len shall pulse for one cycle; the transfer still ends normally.
REQ-015 A request with pN_req_len = 0 shall not be forwarded:
- The block acks it internally in REQ (pN_req_ack = 1, app_req = 0).
- err_len pulses, and the state returns to IDLE.
REQ-016 Requests arriving during REQ or XFER shall wait; there is no preemption.
REQ-017 pN_rd_data shall equal app_rd_data for both ports (qualified only by pN_rd_valid).
REQ-018 app_wr_data and app_wr_en_n shall hold the granted port's values in IDLE and REQ as well as XFER.

Reset
REQ-019 While sdram_resetn = 0, the block shall set:
- state = IDLE, last_grant = 1, grant = 0, beat counter = 0.
- All outputs to 0, except app_req_wr_n = 1 and app_wr_en_n all ones.
REQ-020 Reset asserted mid-transfer shall abandon the transfer immediately with no pN_last or err_len.

Verification
REQ-021 p0 write, len 4, app_req_ack after 3 cycles -> p0_req_ack one cycle, 4 p0_wr_next, p0_last on beat 4, err_len = 0, grant = 0.
REQ-022 p0 and p1 both request from reset -> p0 served first, then p1, then p0 again if it re-requests.
REQ-023 p1 read, len 2, while p0 requests -> p0 sees no rd_valid or ack until p1_last; p0 granted 1 cycle after p1 returns to IDLE.
REQ-024 p0 read, len 4, with app_last_rd on beat 3 -> transfer ends, err_len pulses once.
REQ-025 p1 request with len 0 -> p1_req_ack pulses, app_req stays 0, err_len = 1.
REQ-026 sdram_resetn driven low during XFER -> all outputs at reset values asynchronously, busy = 0.
